// File: rtl/filter_conv_kxk_pipe.sv
// filter_conv_kxk_pipe: pipelined KxK convolution with double-buffered
// signed coefficients, runtime shift normalisation, optional |sum| output
// and a saturating clamp to the pixel range.
// Optional build macro FILTER_CONV_ROUND_EN: round half up before the
// normalising shift. Without it, the shift truncates toward -inf.
// Pipeline: S1 products -> S2 row sums -> S3 total/shift/clamp (o_y).
module filter_conv_kxk_pipe #(
  parameter int KSIZE      = 5,
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 i_coef_we,
  input  logic [ADDR_WIDTH-1:0]                i_coef_addr,
  input  logic signed [COEF_WIDTH-1:0]         i_coef_wdata,
  input  logic                                 i_coef_commit,
  input  logic [3:0]                           i_shift,
  input  logic                                 i_abs_en,
  input  logic                                 i_de,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]    i_win,
  output logic                                 o_de,
  output logic [DATA_WIDTH-1:0]                o_y
);

  localparam int NTAP   = KSIZE * KSIZE;
  localparam int CENTRE = (NTAP - 1) / 2;
  localparam int PW     = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int RW     = PW + $clog2(KSIZE);
  localparam int AW     = PW + $clog2(NTAP);
  // one extra bit so the rounding bias and the magnitude never wrap
  localparam int SW     = AW + 1;
  localparam logic signed [SW-1:0] YMAX = SW'((1 << DATA_WIDTH) - 1);

  logic signed [COEF_WIDTH-1:0] shadow [NTAP];
  logic signed [COEF_WIDTH-1:0] active [NTAP];

  logic signed [PW-1:0] prod_d [NTAP];
  logic signed [PW-1:0] prod   [NTAP];
  logic signed [RW-1:0] row_d  [KSIZE];
  logic signed [RW-1:0] row    [KSIZE];

  logic signed [AW-1:0] total;
  logic signed [SW-1:0] biased;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] mag;
  logic [DATA_WIDTH-1:0] y_d;

  logic v1;
  logic v2;

  // Coefficient banks: commit copies the pre-edge shadow, so a same-cycle
  // write lands only in the shadow bank. Out-of-range addresses match no tap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAP; i++) begin
        shadow[i] <= (i == CENTRE) ? COEF_WIDTH'(1) : '0;
        active[i] <= (i == CENTRE) ? COEF_WIDTH'(1) : '0;
      end
    end else begin
      if (i_coef_commit) active <= shadow;
      for (int i = 0; i < NTAP; i++) begin
        if (i_coef_we && (i_coef_addr == ADDR_WIDTH'(i))) shadow[i] <= i_coef_wdata;
      end
    end
  end

  // Per-tap products: pixel zero-extended to a signed value times active coef
  always_comb begin
    for (int i = 0; i < NTAP; i++) begin
      prod_d[i] = PW'($signed({1'b0, i_win[i*DATA_WIDTH +: DATA_WIDTH]})) * PW'(active[i]);
    end
  end

  // Row sums of the registered products
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < KSIZE; c++) begin
        row_d[r] = row_d[r] + RW'(prod[r*KSIZE + c]);
      end
    end
  end

  // Total, normalise, then abs or clamp into the pixel range
  always_comb begin
    total = '0;
    for (int r = 0; r < KSIZE; r++) begin
      total = total + AW'(row[r]);
    end
`ifdef FILTER_CONV_ROUND_EN
    biased = SW'(total);
    if (i_shift != 4'd0) biased = SW'(total) + (SW'(1) <<< (i_shift - 4'd1));
`else
    biased = SW'(total);
`endif
    shifted = biased >>> i_shift;
    mag     = (i_abs_en && shifted[SW-1]) ? -shifted : shifted;
    y_d     = '0;
    if (mag[SW-1])     y_d = '0;
    else if (mag > YMAX) y_d = '1;
    else               y_d = mag[DATA_WIDTH-1:0];
  end

  // S1/S2 datapath registers advance only with their valid bit
  always_ff @(posedge clk) begin
    if (i_de) prod <= prod_d;
    if (v1)   row  <= row_d;
  end

  // Valid chain always shifts so bubbles pass through unchanged
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      o_de <= 1'b0;
    end else begin
      v1   <= i_de;
      v2   <= v1;
      o_de <= v2;
    end
  end

  // Output pixel holds its last value between valid results
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   o_y <= '0;
    else if (v2) o_y <= y_d;
  end

endmodule

// File: tb/tb_filter_conv_kxk_pipe.sv
// Self-checking bench for filter_conv_kxk_pipe (KSIZE=5, 8-bit pixels/coefs).
// Reference: coefficient banks as int arrays, window sum as plain integer
// arithmetic; the shift/abs/clamp rule is applied when the result is due.
module tb_filter_conv_kxk_pipe;
  localparam int K   = 5;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int AWD = 6;
  localparam int NT  = K * K;
  localparam int WW  = NT * DW;

  logic           clk = 1'b0;
  logic           rstn;
  logic           i_coef_we;
  logic [AWD-1:0] i_coef_addr;
  logic [CW-1:0]  i_coef_wdata;
  logic           i_coef_commit;
  logic [3:0]     i_shift;
  logic           i_abs_en;
  logic           i_de;
  logic [WW-1:0]  i_win;
  logic           o_de;
  logic [DW-1:0]  o_y;

  filter_conv_kxk_pipe #(.KSIZE(K), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .ADDR_WIDTH(AWD)) dut (
    .clk(clk), .rstn(rstn),
    .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_wdata(i_coef_wdata),
    .i_coef_commit(i_coef_commit), .i_shift(i_shift), .i_abs_en(i_abs_en),
    .i_de(i_de), .i_win(i_win), .o_de(o_de), .o_y(o_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int shadow_m [NT];
  int active_m [NT];
  bit de_q [$];
  int sum_q [$];
  int last_y;

  function automatic int ref_y(int s, int sh, bit ab);
    int v;
    v = s;
`ifdef FILTER_CONV_ROUND_EN
    if (sh > 0) v = v + (1 << (sh - 1));
`endif
    v = v >>> sh;
    if (ab && v < 0) v = -v;
    if (v < 0) v = 0;
    if (v > (1 << DW) - 1) v = (1 << DW) - 1;
    return v;
  endfunction

  function automatic int win_sum(logic [WW-1:0] w);
    int s;
    s = 0;
    for (int i = 0; i < NT; i++) s += int'(w[i*DW +: DW]) * active_m[i];
    return s;
  endfunction

  function automatic logic [WW-1:0] rand_win();
    logic [WW-1:0] w;
    for (int i = 0; i < NT; i++) w[i*DW +: DW] = DW'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic logic [WW-1:0] flat_win(int pix);
    logic [WW-1:0] w;
    for (int i = 0; i < NT; i++) w[i*DW +: DW] = DW'(pix);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      shadow_m[i] = (i == (NT - 1) / 2) ? 1 : 0;
      active_m[i] = shadow_m[i];
    end
    de_q.delete();
    sum_q.delete();
    de_q.push_back(1'b0);
    de_q.push_back(1'b0);
    last_y = 0;
  endtask

  // One clock: drive inputs, update the model, then check outputs after the edge
  task automatic step(bit de, logic [WW-1:0] w, bit we, int addr, int wdata, bit commit);
    bit exp_de;
    logic [DW-1:0] exp_y;
    i_de          = de;
    i_win         = w;
    i_coef_we     = we;
    i_coef_addr   = AWD'(addr);
    i_coef_wdata  = CW'(wdata);
    i_coef_commit = commit;
    de_q.push_back(de);
    if (de) sum_q.push_back(win_sum(w));
    if (commit) active_m = shadow_m;
    if (we && addr < NT) shadow_m[addr] = wdata;
    @(posedge clk);
    #1;
    exp_de = de_q.pop_front();
    if (exp_de) last_y = ref_y(sum_q.pop_front(), int'(i_shift), i_abs_en);
    exp_y = DW'(last_y);
    checks++;
    assert (o_de === exp_de) else begin
      errors++;
      $error("FAIL o_de observed=%0b expected=%0b", o_de, exp_de);
    end
    checks++;
    assert (o_y === exp_y) else begin
      errors++;
      $error("FAIL o_y observed=%0d expected=%0d", o_y, exp_y);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic load_shadow(int vals [NT]);
    for (int a = 0; a < NT; a++) step(1'b0, '0, 1'b1, a, vals[a], 1'b0);
  endtask

  initial begin
    logic [WW-1:0] w;
    int kv [NT];

    rstn = 1'b0;
    i_coef_we = 1'b0; i_coef_addr = '0; i_coef_wdata = '0; i_coef_commit = 1'b0;
    i_shift = 4'd0; i_abs_en = 1'b0; i_de = 1'b0; i_win = '0;
    model_reset();
    #22;
    checks++;
    assert (o_de === 1'b0) else begin errors++; $error("FAIL reset_de observed=%0b expected=0", o_de); end
    checks++;
    assert (o_y === 8'd0) else begin errors++; $error("FAIL reset_y observed=%0d expected=0", o_y); end
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // identity kernel after reset, 3-cycle burst with centre 173
    for (int i = 0; i < 3; i++) begin
      w = rand_win();
      w[12*DW +: DW] = 8'd173;
      step(1'b1, w, 1'b0, 0, 0, 1'b0);
    end
    idle(4);

    // all-ones kernel on a flat 200 window: clamp, then shift by 5
    for (int a = 0; a < NT; a++) kv[a] = 1;
    load_shadow(kv);
    step(1'b0, '0, 1'b0, 0, 0, 1'b1);
    i_shift = 4'd4;
    step(1'b1, flat_win(200), 1'b0, 0, 0, 1'b0);
    idle(3);
    i_shift = 4'd5;
    step(1'b1, flat_win(200), 1'b0, 0, 0, 1'b0);
    idle(3);
    i_shift = 4'd0;

    // horizontal Sobel row: negative sum clamps to 0 or yields magnitude
    for (int a = 0; a < NT; a++) kv[a] = (a == 10) ? -1 : (a == 14) ? 1 : 0;
    load_shadow(kv);
    step(1'b0, '0, 1'b0, 0, 0, 1'b1);
    w = rand_win();
    w[10*DW +: DW] = 8'd255;
    w[14*DW +: DW] = 8'd0;
    i_abs_en = 1'b0;
    step(1'b1, w, 1'b0, 0, 0, 1'b0);
    idle(3);
    i_abs_en = 1'b1;
    step(1'b1, w, 1'b0, 0, 0, 1'b0);
    idle(3);
    i_abs_en = 1'b0;

    // continuous stream with a kernel commit in the middle
    for (int a = 0; a < NT; a++) kv[a] = $urandom_range(0, 2);
    load_shadow(kv);
    i_shift = 4'd5;
    for (int i = 0; i < 12; i++) step(1'b1, rand_win(), 1'b0, 0, 0, (i == 5));
    idle(3);
    i_shift = 4'd0;

    // same-cycle write + commit keeps old centre; second commit picks it up
    for (int a = 0; a < NT; a++) kv[a] = (a == 12) ? 1 : 0;
    load_shadow(kv);
    step(1'b0, '0, 1'b0, 0, 0, 1'b1);
    step(1'b0, '0, 1'b1, 12, 3, 1'b1);
    w = rand_win();
    w[12*DW +: DW] = 8'd50;
    step(1'b1, w, 1'b0, 0, 0, 1'b0);
    idle(3);
    step(1'b0, '0, 1'b0, 0, 0, 1'b1);
    step(1'b1, w, 1'b0, 0, 0, 1'b0);
    idle(3);
    step(1'b0, '0, 1'b1, 40, 7, 1'b0);
    step(1'b0, '0, 1'b0, 0, 0, 1'b1);
    step(1'b1, w, 1'b0, 0, 0, 1'b0);
    idle(3);

    // randomized traffic: bubbles, writes (some out of range), commits, modes
    for (int n = 0; n < 300; n++) begin
      if (n % 20 == 0) begin
        i_shift  = 4'($urandom_range(0, 6));
        i_abs_en = 1'($urandom_range(0, 1));
      end
      step(($urandom_range(0, 3) != 0), rand_win(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 63), int'($urandom_range(0, 15)) - 8, ($urandom_range(0, 15) == 0));
    end
    idle(3);
    i_shift  = 4'd0;
    i_abs_en = 1'b0;

    // reset asserted with three windows in flight
    for (int a = 0; a < NT; a++) kv[a] = 2;
    load_shadow(kv);
    step(1'b0, '0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, rand_win(), 1'b0, 0, 0, 1'b0);
    i_de = 1'b0;
    i_coef_we = 1'b0;
    i_coef_commit = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    assert (o_de === 1'b0) else begin errors++; $error("FAIL midrst_de observed=%0b expected=0", o_de); end
    checks++;
    assert (o_y === 8'd0) else begin errors++; $error("FAIL midrst_y observed=%0d expected=0", o_y); end
    model_reset();
    #8;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    idle(5);
    w = rand_win();
    step(1'b1, w, 1'b0, 0, 0, 1'b0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
